// File: rtl/brief_hamming_matcher.sv
// BRIEF descriptor matcher: each accepted descriptor is stored in the current-frame bank and
// searched (minimum Hamming distance) against the previous-frame bank. Build macro: SECOND_BEST_EN.
module brief_hamming_matcher #(
    parameter int PATTERN = 120,
    parameter int X_WIDTH = 10,
    parameter int Y_WIDTH = 10,
    parameter int MAX_KP  = 64,
    parameter int THRESH  = 30,
    parameter int MARGIN  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         frame_end,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [X_WIDTH-1:0]           in_x,
    input  logic [Y_WIDTH-1:0]           in_y,
    input  logic [PATTERN-1:0]           in_desc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [X_WIDTH-1:0]           out_prev_x,
    output logic [Y_WIDTH-1:0]           out_prev_y,
    output logic [X_WIDTH-1:0]           out_curr_x,
    output logic [Y_WIDTH-1:0]           out_curr_y,
    output logic [$clog2(PATTERN+1)-1:0] out_dist,
    output logic                         overflow,
    output logic [1:0]                   dbg_state_o
);

    localparam int CW = $clog2(MAX_KP + 1);
    localparam int IW = (MAX_KP > 1) ? $clog2(MAX_KP) : 1;
    localparam int DW = $clog2(PATTERN + 1);
    localparam int EW = X_WIDTH + Y_WIDTH + PATTERN;

    localparam logic [CW-1:0] MAX_KP_C = CW'(MAX_KP);
    localparam logic [DW-1:0] THRESH_C = DW'(THRESH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_EMIT   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                wr_sel_q, wr_sel_d;
    logic [CW-1:0]       cur_cnt_q, cur_cnt_d;
    logic [CW-1:0]       prev_cnt_q, prev_cnt_d;
    logic                pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [X_WIDTH-1:0]  cx_q, cx_d;
    logic [Y_WIDTH-1:0]  cy_q, cy_d;
    logic [PATTERN-1:0]  desc_q, desc_d;
    logic [DW-1:0]       dist_q, dist_d;
    logic [X_WIDTH-1:0]  dx_q, dx_d;
    logic [Y_WIDTH-1:0]  dy_q, dy_d;
    logic [DW-1:0]       best_q, best_d;
    logic [X_WIDTH-1:0]  bx_q, bx_d;
    logic [Y_WIDTH-1:0]  by_q, by_d;
    logic                out_valid_q, out_valid_d;
    logic [X_WIDTH-1:0]  opx_q, opx_d;
    logic [Y_WIDTH-1:0]  opy_q, opy_d;
    logic [X_WIDTH-1:0]  ocx_q, ocx_d;
    logic [Y_WIDTH-1:0]  ocy_q, ocy_d;
    logic [DW-1:0]       odist_q, odist_d;
`ifdef SECOND_BEST_EN
    logic [DW-1:0]       sb_q, sb_d;
    logic [DW-1:0]       nsb;
`endif

    logic                we;
    logic [EW-1:0]       rd_entry;
    logic                better;
    logic [DW-1:0]       nb;
    logic [X_WIDTH-1:0]  nbx;
    logic [Y_WIDTH-1:0]  nby;
    logic                match_ok;

    // Entry layout: {x, y, descriptor}. Bank wr_sel is filled, bank ~wr_sel is searched.
    logic [EW-1:0] bank_q [2][MAX_KP];

    function automatic logic [DW-1:0] popcount(input logic [PATTERN-1:0] v);
        logic [DW-1:0] c;
        c = '0;
        for (int i = 0; i < PATTERN; i++) c = c + DW'(v[i]);
        return c;
    endfunction

    // Both ports are valid/ready: a transfer happens on a rising clk edge where valid and ready
    // are both high; out_valid, once raised, holds with its payload stable until that edge.
    assign in_ready    = (state_q == S_IDLE) && !pending_q;
    assign out_valid   = out_valid_q;
    assign out_prev_x  = opx_q;
    assign out_prev_y  = opy_q;
    assign out_curr_x  = ocx_q;
    assign out_curr_y  = ocy_q;
    assign out_dist    = odist_q;
    assign overflow    = overflow_q;
    assign dbg_state_o = state_q;

    assign rd_entry = bank_q[~wr_sel_q][idx_q[IW-1:0]];

    // Distance is registered one cycle ahead of the compare, so dist_q trails idx_q by one entry.
    always_comb begin
        better = dist_q < best_q;
        nb     = better ? dist_q : best_q;
        nbx    = better ? dx_q : bx_q;
        nby    = better ? dy_q : by_q;
`ifdef SECOND_BEST_EN
        nsb      = better ? best_q : ((dist_q < sb_q) ? dist_q : sb_q);
        match_ok = (nb <= THRESH_C) && ((nsb - nb) >= DW'(MARGIN));
`else
        match_ok = (nb <= THRESH_C);
`endif
    end

`ifndef SECOND_BEST_EN
    logic unused_margin;
    assign unused_margin = ^MARGIN;
`endif

    always_comb begin
        state_d     = state_q;
        wr_sel_d    = wr_sel_q;
        cur_cnt_d   = cur_cnt_q;
        prev_cnt_d  = prev_cnt_q;
        pending_d   = pending_q | frame_end;
        overflow_d  = overflow_q;
        idx_d       = idx_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        desc_d      = desc_q;
        dist_d      = dist_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        best_d      = best_q;
        bx_d        = bx_q;
        by_d        = by_q;
        out_valid_d = out_valid_q;
        opx_d       = opx_q;
        opy_d       = opy_q;
        ocx_d       = ocx_q;
        ocy_d       = ocy_q;
        odist_d     = odist_q;
`ifdef SECOND_BEST_EN
        sb_d        = sb_q;
`endif
        we          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    cx_d   = in_x;
                    cy_d   = in_y;
                    desc_d = in_desc;
                    if (cur_cnt_q < MAX_KP_C) begin
                        we        = 1'b1;
                        cur_cnt_d = cur_cnt_q + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (prev_cnt_q != '0) begin
                        state_d = S_SEARCH;
                        idx_d   = '0;
                        best_d  = '1;
`ifdef SECOND_BEST_EN
                        sb_d    = '1;
`endif
                    end
                end else if (pending_q) begin
                    wr_sel_d   = ~wr_sel_q;
                    prev_cnt_d = cur_cnt_q;
                    cur_cnt_d  = '0;
                    overflow_d = 1'b0;
                    pending_d  = frame_end;
                end
            end

            S_SEARCH: begin
                dist_d = popcount(desc_q ^ rd_entry[PATTERN-1:0]);
                dy_d   = rd_entry[PATTERN +: Y_WIDTH];
                dx_d   = rd_entry[PATTERN+Y_WIDTH +: X_WIDTH];
                idx_d  = idx_q + CW'(1);
                if (idx_q != '0) begin
                    best_d = nb;
                    bx_d   = nbx;
                    by_d   = nby;
`ifdef SECOND_BEST_EN
                    sb_d   = nsb;
`endif
                end
                if (idx_q == prev_cnt_q) begin
                    if (match_ok) begin
                        state_d     = S_EMIT;
                        out_valid_d = 1'b1;
                        opx_d       = nbx;
                        opy_d       = nby;
                        ocx_d       = cx_q;
                        ocy_d       = cy_q;
                        odist_d     = nb;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_sel_q    <= 1'b0;
            cur_cnt_q   <= '0;
            prev_cnt_q  <= '0;
            pending_q   <= 1'b0;
            overflow_q  <= 1'b0;
            idx_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            desc_q      <= '0;
            dist_q      <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            best_q      <= '1;
            bx_q        <= '0;
            by_q        <= '0;
            out_valid_q <= 1'b0;
            opx_q       <= '0;
            opy_q       <= '0;
            ocx_q       <= '0;
            ocy_q       <= '0;
            odist_q     <= '0;
`ifdef SECOND_BEST_EN
            sb_q        <= '1;
`endif
        end else begin
            state_q     <= state_d;
            wr_sel_q    <= wr_sel_d;
            cur_cnt_q   <= cur_cnt_d;
            prev_cnt_q  <= prev_cnt_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            idx_q       <= idx_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            desc_q      <= desc_d;
            dist_q      <= dist_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            best_q      <= best_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            out_valid_q <= out_valid_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            ocx_q       <= ocx_d;
            ocy_q       <= ocy_d;
            odist_q     <= odist_d;
`ifdef SECOND_BEST_EN
            sb_q        <= sb_d;
`endif
        end
    end

    // Bank contents need no reset: the counters define which entries are live.
    always_ff @(posedge clk) begin
        if (reset && we) begin
            bank_q[wr_sel_q][cur_cnt_q[IW-1:0]] <= {in_x, in_y, in_desc};
        end
    end

endmodule

// File: tb/tb_brief_hamming_matcher.sv
// Self-checking bench for brief_hamming_matcher: randomized descriptors checked against a
// frame-level reference model (queues of stored descriptors, brute-force minimum distance).
module tb_brief_hamming_matcher;

    localparam int P      = 120;
    localparam int XW     = 10;
    localparam int YW     = 10;
    localparam int MAX_KP = 64;
    localparam int THRESH = 30;
`ifdef SECOND_BEST_EN
    localparam int MARGIN = 4;
`endif
    localparam int DW     = $clog2(P + 1);
    localparam int OW     = 2 * XW + 2 * YW + DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_end;
    logic          in_valid;
    logic          in_ready;
    logic [XW-1:0] in_x;
    logic [YW-1:0] in_y;
    logic [P-1:0]  in_desc;
    logic          out_valid;
    logic          out_ready;
    logic [XW-1:0] out_prev_x;
    logic [YW-1:0] out_prev_y;
    logic [XW-1:0] out_curr_x;
    logic [YW-1:0] out_curr_y;
    logic [DW-1:0] out_dist;
    logic          overflow;
    logic [1:0]    dbg_state_unused;

    int errors = 0;
    int checks = 0;

    // Reference model state: previous and current frame contents, overflow flag.
    logic [XW-1:0] prev_x[$];
    logic [YW-1:0] prev_y[$];
    logic [P-1:0]  prev_d[$];
    logic [XW-1:0] cur_x[$];
    logic [YW-1:0] cur_y[$];
    logic [P-1:0]  cur_d[$];
    logic          ovf_m;
    logic [OW-1:0] exp_q[$];

    brief_hamming_matcher u_dut (
        .clk         (clk),
        .reset       (reset),
        .frame_end   (frame_end),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_desc     (in_desc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_prev_x  (out_prev_x),
        .out_prev_y  (out_prev_y),
        .out_curr_x  (out_curr_x),
        .out_curr_y  (out_curr_y),
        .out_dist    (out_dist),
        .overflow    (overflow),
        .dbg_state_o (dbg_state_unused)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [P-1:0] rand_desc();
        logic [P-1:0] r;
        for (int i = 0; i < P; i++) r[i] = ($urandom_range(0, 1) == 1);
        return r;
    endfunction

    function automatic logic [P-1:0] flip_bits(input logic [P-1:0] d, input int k);
        logic [P-1:0] r;
        int b;
        r = d;
        for (int i = 0; i < k; i++) begin
            b = $urandom_range(0, P - 1);
            r[b] = ~r[b];
        end
        return r;
    endfunction

    task automatic model_swap();
        prev_x = cur_x;
        prev_y = cur_y;
        prev_d = cur_d;
        cur_x.delete();
        cur_y.delete();
        cur_d.delete();
        ovf_m = 1'b0;
    endtask

    task automatic model_clear();
        prev_x.delete();
        prev_y.delete();
        prev_d.delete();
        cur_x.delete();
        cur_y.delete();
        cur_d.delete();
        exp_q.delete();
        ovf_m = 1'b0;
    endtask

    // Sends one descriptor and checks the whole response. fe_at: -1 none, 0 with the accept,
    // k>0 frame_end pulse k cycles after the accept.
    task automatic send_desc(input logic [XW-1:0] x, input logic [YW-1:0] y,
                             input logic [P-1:0] d, input int hold, input int fe_at);
        int n, best, sb, bi, dd, lat, waitc, exp_lat;
        bit exp_match, stable;
        logic [OW-1:0] got_w, exp_w;
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 300) begin
            step();
            waitc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
            return;
        end
        n = prev_d.size();
        best = 1 << 16;
        sb = 1 << 16;
        bi = 0;
        for (int i = 0; i < n; i++) begin
            dd = $countones(d ^ prev_d[i]);
            if (dd < best) begin
                sb = best;
                best = dd;
                bi = i;
            end else if (dd < sb) begin
                sb = dd;
            end
        end
        exp_match = (n > 0) && (best <= THRESH);
`ifdef SECOND_BEST_EN
        if (sb - best < MARGIN) exp_match = 1'b0;
`endif
        if (exp_match) exp_q.push_back({prev_x[bi], prev_y[bi], x, y, DW'(best)});

        in_x = x;
        in_y = y;
        in_desc = d;
        in_valid = 1'b1;
        frame_end = (fe_at == 0);
        step();
        in_valid = 1'b0;
        frame_end = 1'b0;
        if (cur_d.size() < MAX_KP) begin
            cur_x.push_back(x);
            cur_y.push_back(y);
            cur_d.push_back(d);
        end else begin
            ovf_m = 1'b1;
        end
        checks++;
        if (overflow !== ovf_m) begin
            errors++;
            $display("FAIL overflow: got %b required %b (stored=%0d)", overflow, ovf_m, cur_d.size());
        end

        if (n == 0) begin
            stable = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (out_valid !== 1'b0 || (fe_at < 0 && in_ready !== 1'b1)) stable = 1'b0;
                step();
            end
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL empty_prev: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
            end
        end else begin
            lat = 0;
            while (lat <= n + 6) begin
                lat++;
                if (lat == fe_at) frame_end = 1'b1;
                step();
                frame_end = 1'b0;
                if (out_valid === 1'b1 || in_ready === 1'b1) break;
            end
            exp_lat = n + 1 + ((!exp_match && fe_at >= 0) ? 1 : 0);
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL latency: got %0d clocks required %0d (prev_cnt=%0d)", lat, exp_lat, n);
            end
            checks++;
            if (out_valid !== exp_match) begin
                errors++;
                $display("FAIL out_valid: got %b required %b (best=%0d)", out_valid, exp_match, best);
            end
            if (exp_match) begin
                exp_w = exp_q.pop_front();
                if (out_valid === 1'b1) begin
                    got_w = {out_prev_x, out_prev_y, out_curr_x, out_curr_y, out_dist};
                    checks++;
                    if (got_w !== exp_w) begin
                        errors++;
                        $display("FAIL match_fields: got %h required %h (dist got %0d required %0d)",
                                 got_w, exp_w, out_dist, best);
                    end
                    if (hold > 0) begin
                        out_ready = 1'b0;
                        stable = 1'b1;
                        for (int k = 0; k < hold; k++) begin
                            step();
                            got_w = {out_prev_x, out_prev_y, out_curr_x, out_curr_y, out_dist};
                            if (out_valid !== 1'b1 || in_ready !== 1'b0 || got_w !== exp_w) stable = 1'b0;
                        end
                        checks++;
                        if (!stable) begin
                            errors++;
                            $display("FAIL hold_stable: out_valid=%b in_ready=%b fields=%h required 1/0/%h",
                                     out_valid, in_ready, got_w, exp_w);
                        end
                        out_ready = 1'b1;
                    end
                    step();
                    checks++;
                    if (out_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL transfer: out_valid=%b required 0 after handshake", out_valid);
                    end
                end
            end
        end
        if (fe_at >= 0) model_swap();
    endtask

    task automatic do_frame_end();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        model_swap();
        checks++;
        if (overflow !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_swap: overflow=%b in_ready=%b required 0/1", overflow, in_ready);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        frame_end = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0 || out_dist !== '0 || out_prev_x !== '0 ||
            out_prev_y !== '0 || out_curr_x !== '0 || out_curr_y !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b ovf=%b dist=%0d px=%0d py=%0d cx=%0d cy=%0d required all 0",
                     out_valid, overflow, out_dist, out_prev_x, out_prev_y, out_curr_x, out_curr_y);
        end
        reset = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
        end
        model_clear();
    endtask

    // Scenarios
    logic [P-1:0] a_d[3];

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_empty_prev();
        for (int i = 0; i < 3; i++) begin
            a_d[i] = rand_desc();
            send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), a_d[i], 0, -1);
        end
        do_frame_end();
    endtask

    task automatic test_exact_match();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), a_d[1], 0, -1);
    endtask

    task automatic test_no_match();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), ~a_d[0], 0, -1);
    endtask

    task automatic test_hold();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)),
                  flip_bits(a_d[2], 3), 10, -1);
    endtask

    task automatic test_frame_end_search();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)),
                  flip_bits(a_d[0], 2), 0, 2);
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), prev_d[3], 0, -1);
    endtask

    task automatic test_frame_end_with_accept();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), rand_desc(), 0, 0);
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)),
                  prev_d[prev_d.size() - 1], 0, -1);
    endtask

    task automatic test_back_to_back();
        logic [P-1:0] d;
        int nsend;
        for (int f = 0; f < 4; f++) begin
            do_frame_end();
            nsend = $urandom_range(2, 8);
            for (int j = 0; j < nsend; j++) begin
                if (prev_d.size() > 0 && $urandom_range(0, 3) != 0)
                    d = flip_bits(prev_d[$urandom_range(0, prev_d.size() - 1)], $urandom_range(0, 40));
                else
                    d = rand_desc();
                send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), d,
                          $urandom_range(0, 2), -1);
            end
        end
    endtask

    task automatic test_reset_mid_search();
        do_frame_end();
        while (in_ready !== 1'b1) step();
        in_x = XW'($urandom_range(1, 1023));
        in_y = YW'($urandom_range(1, 1023));
        in_desc = prev_d[0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        apply_reset();
        for (int i = 0; i < 2; i++)
            send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), rand_desc(), 0, -1);
    endtask

    task automatic test_overflow();
        logic [P-1:0] last_d;
        apply_reset();
        for (int i = 0; i < MAX_KP + 1; i++) begin
            last_d = rand_desc();
            send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), last_d, 0, -1);
        end
        do_frame_end();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), prev_d[MAX_KP - 1], 0, -1);
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), last_d, 0, -1);
    endtask

    task automatic test_second_best();
        logic [P-1:0] base, m5, m7;
        apply_reset();
        base = rand_desc();
        m5 = '0;
        m7 = '0;
        for (int i = 0; i < 5; i++) m5[i] = 1'b1;
        for (int i = 10; i < 17; i++) m7[i] = 1'b1;
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), base ^ m5, 0, -1);
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), base ^ m7, 0, -1);
        do_frame_end();
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), base, 0, -1);
        send_desc(XW'($urandom_range(0, 1023)), YW'($urandom_range(0, 1023)), base ^ m5, 3, -1);
    endtask

    initial begin
        reset = 1'b0;
        frame_end = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_y = '0;
        in_desc = '0;
        out_ready = 1'b1;
        ovf_m = 1'b0;
        step();
        test_reset();
        test_empty_prev();
        test_exact_match();
        test_no_match();
        test_hold();
        test_frame_end_search();
        test_frame_end_with_accept();
        test_back_to_back();
        test_reset_mid_search();
        test_overflow();
        test_second_best();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
